// File: rtl/capture_pkg.sv
// capture_pkg: shared types and default sizing for the result_capture block.
// Contents:
//   state_e  - capture FSM states (WATCH, SETTLE, COMMIT)
//   *_DEF    - default parameter values for the top and FIFO
//   entry_t  - packed FIFO entry {data, ts} at the default widths
package capture_pkg;

    localparam int unsigned DATA_W_DEF        = 5;
    localparam int unsigned SETTLE_CYCLES_DEF = 3;
    localparam int unsigned DEPTH_DEF         = 4;
    localparam int unsigned TS_W_DEF          = 8;
    localparam int unsigned GLITCH_W          = 8;

    typedef enum logic [1:0] {
        WATCH  = 2'd0,
        SETTLE = 2'd1,
        COMMIT = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [TS_W_DEF-1:0]   ts;
    } entry_t;

endpackage

// File: rtl/capture_fifo.sv
// capture_fifo: first-word-fall-through FIFO holding committed capture entries.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (empties the FIFO)
//   push, wdata   - write request and entry; accepted when not full or when popping
//   pop           - read request; ignored while empty
//   rdata         - head entry, reads 0 while empty
//   full, empty   - occupancy flags
//   count         - occupancy, 0..DEPTH
module capture_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 13
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_W'(1);
            if (do_pop)  rptr <= rptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: contents are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rptr];
    assign count = count_q;

endmodule

// File: rtl/result_capture.sv
// result_capture: registers the asynchronous result bundle, waits for it to be
// stable for SETTLE_CYCLES evaluations, and commits each new stable value with
// a timestamp into a FIFO drained over valid/ready.
// Build option: define CAPTURE_GLITCH_EN to count rejected candidates on
// glitch_cnt (saturating); otherwise glitch_cnt is tied to 0.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   i_data     - result bundle {o0,o1,o2[1],o2[0],o3}, asynchronous to clk
//   out_valid  - FIFO head valid
//   out_ready  - consumer accepts the head
//   out_data   - committed value at the head (0 when empty)
//   out_ts     - timestamp of the head (0 when empty)
//   out_count  - FIFO occupancy
//   overflow   - sticky: a commit was dropped because the FIFO was full
//   glitch_cnt - rejected-candidate count
module result_capture
    import capture_pkg::*;
#(
    parameter int unsigned DATA_W        = DATA_W_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned DEPTH         = DEPTH_DEF,
    parameter int unsigned TS_W          = TS_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      i_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [TS_W-1:0]        out_ts,
    output logic [$clog2(DEPTH):0] out_count,
    output logic                   overflow,
    output logic [GLITCH_W-1:0]    glitch_cnt
);

    localparam int unsigned CNT_W   = $clog2(SETTLE_CYCLES) + 1;
    localparam int unsigned ENTRY_W = DATA_W + TS_W;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] in_q;
    logic [DATA_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] cand_q, cand_d;
    logic [TS_W-1:0]   cand_ts_q, cand_ts_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TS_W-1:0]   ts_q;
    logic              commit;
    logic              glitch;

    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [ENTRY_W-1:0] head;

    // Input sampling register and free-running timestamp.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q <= '0;
            ts_q <= '0;
        end else begin
            in_q <= i_data;
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // FSM and candidate state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WATCH;
            last_q    <= '0;
            cand_q    <= '0;
            cand_ts_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cand_q    <= cand_d;
            cand_ts_q <= cand_ts_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state: track a candidate until it has matched SETTLE_CYCLES times.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cand_d    = cand_q;
        cand_ts_d = cand_ts_q;
        cnt_d     = cnt_q;
        commit    = 1'b0;
        glitch    = 1'b0;
        case (state_q)
            WATCH: begin
                if (in_q != last_q) begin
                    state_d   = SETTLE;
                    cand_d    = in_q;
                    cand_ts_d = ts_q;
                    cnt_d     = CNT_W'(1);
                end
            end
            SETTLE: begin
                if (in_q == cand_q) begin
                    if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state_d = COMMIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    glitch = 1'b1;
                    if (in_q == last_q) begin
                        state_d = WATCH;
                    end else begin
                        cand_d    = in_q;
                        cand_ts_d = ts_q;
                        cnt_d     = CNT_W'(1);
                    end
                end
            end
            COMMIT: begin
                // last advances even if the push is dropped, so no re-commit.
                commit  = 1'b1;
                last_d  = cand_q;
                state_d = WATCH;
            end
            default: begin
                state_d = WATCH;
            end
        endcase
    end

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    capture_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (commit),
        .pop   (pop),
        .wdata ({cand_q, cand_ts_q}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (out_count)
    );

    assign out_data = head[ENTRY_W-1:TS_W];
    assign out_ts   = head[TS_W-1:0];

    // Sticky drop flag: commit into a full FIFO with no simultaneous pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (commit && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

`ifdef CAPTURE_GLITCH_EN
    // Saturating count of rejected candidates.
    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_cnt <= '0;
        end else if (glitch && (glitch_cnt != {GLITCH_W{1'b1}})) begin
            glitch_cnt <= glitch_cnt + GLITCH_W'(1);
        end
    end
`else
    logic unused_glitch;
    assign unused_glitch = glitch;
    assign glitch_cnt    = '0;
`endif

endmodule

// File: tb/tb_result_capture.sv
// tb_result_capture: directed scenarios with literal expectations plus a
// randomized phase; a transaction-level model predicts the FIFO contents,
// overflow and glitch count, and a negedge process compares every cycle.
module tb_result_capture;
    import capture_pkg::*;

    localparam int unsigned DATA_W = 5;
    localparam int unsigned SC     = 3;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned TS_W   = 8;
`ifdef CAPTURE_GLITCH_EN
    localparam int unsigned GLITCH_ON = 1;
`else
    localparam int unsigned GLITCH_ON = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] i_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TS_W-1:0]   out_ts;
    logic [2:0]        out_count;
    logic              overflow;
    logic [7:0]        glitch_cnt;

    int checks = 0;
    int errors = 0;

    result_capture #(
        .DATA_W        (DATA_W),
        .SETTLE_CYCLES (SC),
        .DEPTH         (DEPTH),
        .TS_W          (TS_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_data     (i_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ts     (out_ts),
        .out_count  (out_count),
        .overflow   (overflow),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Sampled value history is reduced to: the last committed value, the
    // current candidate with its first-seen timestamp, and how many
    // consecutive evaluations it has matched.
    entry_t            m_q[$];
    logic [DATA_W-1:0] m_in_q, m_last, m_cand;
    logic [TS_W-1:0]   m_ts, m_cand_ts;
    int                m_run;
    bit                m_track, m_commit, m_ovf, m_on;
    int                m_glitch;

    initial m_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_in_q = '0; m_last = '0; m_cand = '0;
            m_ts = '0; m_cand_ts = '0;
            m_run = 0; m_track = 1'b0; m_commit = 1'b0; m_ovf = 1'b0;
            m_glitch = 0;
            m_on = 1'b1;
        end else if (m_on) begin
            if (m_q.size() != 0 && out_ready) m_q.delete(0);
            if (m_commit) begin
                if (m_q.size() < DEPTH) m_q.push_back(entry_t'{data: m_cand, ts: m_cand_ts});
                else m_ovf = 1'b1;
                m_last   = m_cand;
                m_commit = 1'b0;
                m_track  = 1'b0;
            end else if (!m_track) begin
                if (m_in_q != m_last) begin
                    m_track = 1'b1; m_cand = m_in_q; m_cand_ts = m_ts; m_run = 1;
                end
            end else if (m_in_q == m_cand) begin
                m_run++;
                if (m_run == int'(SC)) m_commit = 1'b1;
            end else begin
                if (m_glitch < 255) m_glitch++;
                if (m_in_q == m_last) m_track = 1'b0;
                else begin
                    m_cand = m_in_q; m_cand_ts = m_ts; m_run = 1;
                end
            end
            m_in_q = i_data;
            m_ts   = m_ts + 8'd1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_on) begin
            check("m_valid", 32'(out_valid), 32'(m_q.size() != 0));
            check("m_count", 32'(out_count), 32'(m_q.size()));
            check("m_data",  32'(out_data),  (m_q.size() != 0) ? 32'(m_q[0].data) : 32'd0);
            check("m_ts",    32'(out_ts),    (m_q.size() != 0) ? 32'(m_q[0].ts) : 32'd0);
            check("m_ovf",   32'(overflow),  32'(m_ovf));
            check("m_glitch", 32'(glitch_cnt), (GLITCH_ON != 0) ? 32'(m_glitch) : 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int hold;
        rst = 1'b1; i_data = '0; out_ready = 1'b0;
        ticks(2);

        // Reset state, then a quiet input commits nothing.
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_ts",    32'(out_ts),    32'd0);
        check("rst_ovf",   32'(overflow),  32'd0);
        check("rst_glitch", 32'(glitch_cnt), 32'd0);
        rst = 1'b0;
        ticks(20);
        check("quiet_valid", 32'(out_valid), 32'd0);
        check("quiet_ovf",   32'(overflow),  32'd0);

        // Single value: change before edge 10, visible after edge 14 with ts 10.
        do_reset();
        ticks(9);
        i_data = 5'b10110;
        ticks(4);
        check("lat_early", 32'(out_valid), 32'd0);
        tick();
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_data",  32'(out_data),  32'h16);
        check("lat_ts",    32'(out_ts),    32'd10);
        pop_one();
        check("lat_popcnt", 32'(out_count), 32'd0);

        // One-cycle pulse returning to the committed value is a glitch.
        do_reset();
        i_data = 5'b00001;
        tick();
        i_data = 5'b00000;
        ticks(8);
        check("gl_count",  32'(out_count),  32'd0);
        check("gl_glitch", 32'(glitch_cnt), 32'(GLITCH_ON));

        // Five commits with no consumer: four kept, fifth dropped.
        do_reset();
        for (int v = 1; v <= 5; v++) begin
            i_data = 5'(v);
            ticks(6);
        end
        check("ov_count", 32'(out_count), 32'd4);
        check("ov_flag",  32'(overflow),  32'd1);
        for (int k = 1; k <= 4; k++) begin
            check("ov_drain_data", 32'(out_data), 32'(k));
            check("ov_drain_ts",   32'(out_ts),   32'(1 + 6 * (k - 1)));
            pop_one();
        end
        check("ov_empty",  32'(out_count), 32'd0);
        check("ov_sticky", 32'(overflow),  32'd1);

        // Full FIFO with a pop in the commit cycle: push accepted, no overflow.
        do_reset();
        for (int v = 1; v <= 4; v++) begin
            i_data = 5'(v);
            ticks(6);
        end
        i_data = 5'd5;
        ticks(4);
        pop_one();
        check("pp_count", 32'(out_count), 32'd4);
        check("pp_ovf",   32'(overflow),  32'd0);
        check("pp_head",  32'(out_data),  32'd2);
        check("pp_ts",    32'(out_ts),    32'd7);

        // Reset mid-settle with two entries queued discards everything.
        do_reset();
        for (int v = 1; v <= 2; v++) begin
            i_data = 5'(v);
            ticks(6);
        end
        check("mr_pre", 32'(out_count), 32'd2);
        i_data = 5'd3;
        ticks(2);
        do_reset();
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_count", 32'(out_count), 32'd0);
        ticks(6);
        check("mr_data",  32'(out_data),  32'd3);
        check("mr_ts",    32'(out_ts),    32'd1);
        check("mr_cnt1",  32'(out_count), 32'd1);

        // Randomized phase: short/long holds, random backpressure, rare reset.
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                i_data = 5'($urandom_range(0, 7));
                hold = int'($urandom_range(1, 6));
            end
            hold--;
            out_ready = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        out_ready = 1'b0;
        ticks(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
